// File: rtl/ir_led_sched_if.sv
// Request strobes from the IR decoder and LED/status outputs of the scheduler.
interface ir_led_sched_if;
    logic       data_en;
    logic       repeat_en;
    logic       err_en;
    logic       led;
    logic       busy;
    logic [1:0] cur_src;
    logic [7:0] drop_cnt;

    modport master (
        output data_en, repeat_en, err_en,
        input  led, busy, cur_src, drop_cnt
    );

    modport slave (
        input  data_en, repeat_en, err_en,
        output led, busy, cur_src, drop_cnt
    );
endinterface

// File: rtl/ir_led_sched.sv
// Arbitrates new-key, repeat and error blink patterns onto one status LED
// with fixed priority (error > new > repeat), preemption and drop counting.
module ir_led_sched #(
    parameter int unsigned T_NEW_ON   = 10_000_000,
    parameter int unsigned T_REP_ON   = 4_000_000,
    parameter int unsigned T_REP_OFF  = 1_000_000,
    parameter int unsigned T_ERR_ON   = 2_500_000,
    parameter int unsigned T_ERR_OFF  = 2_500_000,
    parameter int unsigned ERR_BLINKS = 3
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    ir_led_sched_if.slave   bus
);

    localparam int unsigned CNT_W = 24;
    localparam int unsigned BLK_W = 2;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_REP  = 2'd1;
    localparam logic [1:0] SRC_NEW  = 2'd2;
    localparam logic [1:0] SRC_ERR  = 2'd3;

    typedef enum logic [2:0] {
        IDLE, NEW_ON, REP_ON, REP_OFF, ERR_ON, ERR_OFF
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [BLK_W-1:0]   blink, blink_nxt;
    logic [2:0]         d0, d1;
    logic [2:0]         req;
    logic [1:0]         req_n;
    logic [1:0]         drop_n;
    logic [1:0]         top_src;
    logic [8:0]         drop_sum;

    function automatic logic [1:0] src_of(input state_t s);
        case (s)
            NEW_ON:           src_of = SRC_NEW;
            REP_ON, REP_OFF:  src_of = SRC_REP;
            ERR_ON, ERR_OFF:  src_of = SRC_ERR;
            default:          src_of = SRC_NONE;
        endcase
    endfunction

    // Request bits ordered {err, new, repeat}; rising edge of the registered input.
    assign req      = d0 & ~d1;
    assign req_n    = 2'(req[0]) + 2'(req[1]) + 2'(req[2]);
    assign drop_sum = 9'(bus.drop_cnt) + 9'(drop_n);

    // Arbitration first; the natural phase sequence runs only when no request is present.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        blink_nxt = blink;
        drop_n    = 2'd0;
        top_src   = SRC_NONE;

        if (req[2])      top_src = SRC_ERR;
        else if (req[1]) top_src = SRC_NEW;
        else if (req[0]) top_src = SRC_REP;

        if (top_src != SRC_NONE) begin
            if (top_src >= src_of(state)) begin
                drop_n = req_n - 2'd1;
                case (top_src)
                    SRC_ERR: begin
                        state_nxt = ERR_ON;
                        cnt_nxt   = CNT_W'(T_ERR_ON - 1);
                        blink_nxt = '0;
                    end
                    SRC_NEW: begin
                        state_nxt = NEW_ON;
                        cnt_nxt   = CNT_W'(T_NEW_ON - 1);
                    end
                    default: begin
                        state_nxt = REP_ON;
                        cnt_nxt   = CNT_W'(T_REP_ON - 1);
                    end
                endcase
            end else begin
                drop_n = req_n;
            end
        end else if (state != IDLE) begin
            if (cnt != '0) begin
                cnt_nxt = cnt - CNT_W'(1);
            end else begin
                case (state)
                    REP_ON: begin
                        state_nxt = REP_OFF;
                        cnt_nxt   = CNT_W'(T_REP_OFF - 1);
                    end
                    ERR_ON: begin
                        state_nxt = ERR_OFF;
                        cnt_nxt   = CNT_W'(T_ERR_OFF - 1);
                    end
                    ERR_OFF: begin
                        if (blink < BLK_W'(ERR_BLINKS - 1)) begin
                            state_nxt = ERR_ON;
                            cnt_nxt   = CNT_W'(T_ERR_ON - 1);
                            blink_nxt = blink + BLK_W'(1);
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    // State, edge detectors and registered outputs, all derived from the next state.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            blink        <= '0;
            d0           <= '0;
            d1           <= '0;
            bus.led      <= 1'b0;
            bus.busy     <= 1'b0;
            bus.cur_src  <= SRC_NONE;
            bus.drop_cnt <= '0;
        end else begin
            d0           <= {bus.err_en, bus.data_en, bus.repeat_en};
            d1           <= d0;
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            blink        <= blink_nxt;
            bus.led      <= (state_nxt == NEW_ON) || (state_nxt == REP_ON) ||
                            (state_nxt == ERR_ON);
            bus.busy     <= (state_nxt != IDLE);
            bus.cur_src  <= src_of(state_nxt);
            bus.drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

endmodule
